// File: rtl/tank_game_pkg.sv
// Shared types and widths for the tank game datapath.
// Hit-scan state encoding plus position and score widths.
package tank_game_pkg;

    localparam int POS_W     = 10;
    localparam int SCORE_W   = 4;
    localparam int SCORE_MAX = 15;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_SCAN    = 3'd1,
        ST_RESOLVE = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RESTART = 3'd4,
        ST_OVER    = 3'd5
    } hit_state_t;

endpackage

// File: rtl/bullet_box_check.sv
// Combinational test of one bullet against one square tank hitbox.
// Low bound saturates at 0; high bound carries an extra bit so it never wraps.
module bullet_box_check
    import tank_game_pkg::*;
(
    input  logic [POS_W-1:0] bullet_x_i,
    input  logic [POS_W-1:0] bullet_y_i,
    input  logic             active_i,
    input  logic [POS_W-1:0] tank_x_i,
    input  logic [POS_W-1:0] tank_y_i,
    input  logic [POS_W-1:0] size_i,
    output logic             hit_o
);

    logic [POS_W-1:0] lo_x, lo_y;
    logic [POS_W:0]   hi_x, hi_y;

    always_comb begin
        lo_x  = (tank_x_i >= size_i) ? (tank_x_i - size_i) : '0;
        lo_y  = (tank_y_i >= size_i) ? (tank_y_i - size_i) : '0;
        hi_x  = {1'b0, tank_x_i} + {1'b0, size_i};
        hi_y  = {1'b0, tank_y_i} + {1'b0, size_i};
        hit_o = active_i
             && (bullet_x_i >= lo_x) && ({1'b0, bullet_x_i} <= hi_x)
             && (bullet_y_i >= lo_y) && ({1'b0, bullet_y_i} <= hi_y);
    end

endmodule

// File: rtl/tank_hit_sequencer.sv
// Per-frame hit-scan controller: snapshots tanks and bullets on a frame tick,
// scans one slot per clock, then scores the round and runs play/hold/restart/over.
module tank_hit_sequencer
    import tank_game_pkg::*;
#(
    parameter int NUM_BULLETS = 6,
    parameter int HOLD_FRAMES = 60,
    parameter int WIN_SCORE   = 5
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         frame_tick,
    input  logic [POS_W-1:0]             Tank1_X_Pos,
    input  logic [POS_W-1:0]             Tank1_Y_Pos,
    input  logic [POS_W-1:0]             Tank2_X_Pos,
    input  logic [POS_W-1:0]             Tank2_Y_Pos,
    input  logic [POS_W-1:0]             Tank_Size,
    input  logic [NUM_BULLETS*POS_W-1:0] Bullet_X_Pos,
    input  logic [NUM_BULLETS*POS_W-1:0] Bullet_Y_Pos,
    input  logic [NUM_BULLETS-1:0]       isBulletActive,
    output logic [NUM_BULLETS-1:0]       bullet_kill,
    output logic                         tank1_hit,
    output logic                         tank2_hit,
    output logic                         freeze,
    output logic                         round_restart,
    output logic [SCORE_W-1:0]           score1,
    output logic [SCORE_W-1:0]           score2,
    output logic                         game_over,
    output logic                         scan_busy,
    output logic [2:0]                   dbg_state_o
);

    localparam int IDX_W = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
    localparam int CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BULLETS - 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(HOLD_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SAT      = SCORE_W'(SCORE_MAX);

    hit_state_t                   state_q;
    logic [POS_W-1:0]             t1x_q, t1y_q, t2x_q, t2y_q, size_q;
    logic [NUM_BULLETS*POS_W-1:0] bx_q, by_q;
    logic [NUM_BULLETS-1:0]       act_q, kill_acc_q, bullet_kill_q;
    logic [IDX_W-1:0]             idx_q;
    logic [CNT_W-1:0]             cnt_q;
    logic                         h1_acc_q, h2_acc_q;
    logic                         tank1_hit_q, tank2_hit_q, freeze_q, round_restart_q;
    logic                         game_over_q, scan_busy_q;
    logic [SCORE_W-1:0]           score1_q, score2_q, score1_d, score2_d;
    logic [POS_W-1:0]             cur_x, cur_y;
    logic                         cur_act, hit1, hit2;

    // Time-share the two comparators across slots by idx.
    always_comb begin
        cur_x   = '0;
        cur_y   = '0;
        cur_act = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_x   = bx_q[i*POS_W +: POS_W];
                cur_y   = by_q[i*POS_W +: POS_W];
                cur_act = act_q[i];
            end
        end
    end

    bullet_box_check u_chk_tank1 (
        .bullet_x_i (cur_x),
        .bullet_y_i (cur_y),
        .active_i   (cur_act),
        .tank_x_i   (t1x_q),
        .tank_y_i   (t1y_q),
        .size_i     (size_q),
        .hit_o      (hit1)
    );

    bullet_box_check u_chk_tank2 (
        .bullet_x_i (cur_x),
        .bullet_y_i (cur_y),
        .active_i   (cur_act),
        .tank_x_i   (t2x_q),
        .tank_y_i   (t2y_q),
        .size_i     (size_q),
        .hit_o      (hit2)
    );

    // A tank hit alone scores for the opponent; a mutual hit is a draw.
    always_comb begin
        score1_d = score1_q;
        score2_d = score2_q;
        if (h1_acc_q && !h2_acc_q && (score2_q != SAT)) score2_d = score2_q + SCORE_W'(1);
        if (h2_acc_q && !h1_acc_q && (score1_q != SAT)) score1_d = score1_q + SCORE_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= ST_WAIT;
            t1x_q           <= '0;
            t1y_q           <= '0;
            t2x_q           <= '0;
            t2y_q           <= '0;
            size_q          <= '0;
            bx_q            <= '0;
            by_q            <= '0;
            act_q           <= '0;
            idx_q           <= '0;
            cnt_q           <= '0;
            kill_acc_q      <= '0;
            h1_acc_q        <= 1'b0;
            h2_acc_q        <= 1'b0;
            bullet_kill_q   <= '0;
            tank1_hit_q     <= 1'b0;
            tank2_hit_q     <= 1'b0;
            freeze_q        <= 1'b0;
            round_restart_q <= 1'b0;
            score1_q        <= '0;
            score2_q        <= '0;
            game_over_q     <= 1'b0;
            scan_busy_q     <= 1'b0;
        end else begin
            bullet_kill_q   <= '0;
            round_restart_q <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (frame_tick) begin
                        t1x_q       <= Tank1_X_Pos;
                        t1y_q       <= Tank1_Y_Pos;
                        t2x_q       <= Tank2_X_Pos;
                        t2y_q       <= Tank2_Y_Pos;
                        size_q      <= Tank_Size;
                        bx_q        <= Bullet_X_Pos;
                        by_q        <= Bullet_Y_Pos;
                        act_q       <= isBulletActive;
                        idx_q       <= '0;
                        kill_acc_q  <= '0;
                        h1_acc_q    <= 1'b0;
                        h2_acc_q    <= 1'b0;
                        scan_busy_q <= 1'b1;
                        state_q     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    for (int i = 0; i < NUM_BULLETS; i++) begin
                        if (idx_q == IDX_W'(i) && (hit1 || hit2)) kill_acc_q[i] <= 1'b1;
                    end
                    if (hit1) h1_acc_q <= 1'b1;
                    if (hit2) h2_acc_q <= 1'b1;
                    if (idx_q == LAST_IDX) state_q <= ST_RESOLVE;
                    else                   idx_q   <= idx_q + IDX_W'(1);
                end
                ST_RESOLVE: begin
                    bullet_kill_q <= kill_acc_q;
                    tank1_hit_q   <= h1_acc_q;
                    tank2_hit_q   <= h2_acc_q;
                    score1_q      <= score1_d;
                    score2_q      <= score2_d;
                    scan_busy_q   <= 1'b0;
                    if (!h1_acc_q && !h2_acc_q) begin
                        state_q <= ST_WAIT;
                    end else if ((score1_d >= WIN) || (score2_d >= WIN)) begin
                        freeze_q    <= 1'b1;
                        game_over_q <= 1'b1;
                        state_q     <= ST_OVER;
                    end else begin
                        freeze_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (frame_tick) begin
                        if (cnt_q == LAST_CNT) begin
                            round_restart_q <= 1'b1;
                            freeze_q        <= 1'b0;
                            tank1_hit_q     <= 1'b0;
                            tank2_hit_q     <= 1'b0;
                            state_q         <= ST_RESTART;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_RESTART: state_q <= ST_WAIT;
                ST_OVER:    state_q <= ST_OVER;
                default:    state_q <= ST_WAIT;
            endcase
        end
    end

    assign bullet_kill   = bullet_kill_q;
    assign tank1_hit     = tank1_hit_q;
    assign tank2_hit     = tank2_hit_q;
    assign freeze        = freeze_q;
    assign round_restart = round_restart_q;
    assign score1        = score1_q;
    assign score2        = score2_q;
    assign game_over     = game_over_q;
    assign scan_busy     = scan_busy_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_tank_hit_sequencer.sv
// Bench for tank_hit_sequencer: directed rounds from the game rules plus
// randomized frames, all checked against a frame-level reference model.
module tb_tank_hit_sequencer;
    import tank_game_pkg::*;

    localparam int NB   = 6;
    localparam int HOLD = 60;
    localparam int WIN  = 5;

    logic          clk, rst, tick;
    logic [9:0]    t1x, t1y, t2x, t2y, tsz;
    logic [NB*10-1:0] bx, by;
    logic [NB-1:0] act;
    logic [NB-1:0] bullet_kill;
    logic          tank1_hit, tank2_hit, freeze, round_restart, game_over, scan_busy;
    logic [3:0]    score1, score2;
    logic [2:0]    dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [NB-1:0] exp_q[$];

    // reference model state
    int m_s1, m_s2, m_mode;  // mode: 0 play, 1 hold, 2 over
    bit m_h1, m_h2;

    tank_hit_sequencer #(.NUM_BULLETS(NB), .HOLD_FRAMES(HOLD), .WIN_SCORE(WIN)) dut (
        .Clk(clk), .Reset(rst), .frame_tick(tick),
        .Tank1_X_Pos(t1x), .Tank1_Y_Pos(t1y), .Tank2_X_Pos(t2x), .Tank2_Y_Pos(t2y),
        .Tank_Size(tsz), .Bullet_X_Pos(bx), .Bullet_Y_Pos(by), .isBulletActive(act),
        .bullet_kill(bullet_kill), .tank1_hit(tank1_hit), .tank2_hit(tank2_hit),
        .freeze(freeze), .round_restart(round_restart), .score1(score1), .score2(score2),
        .game_over(game_over), .scan_busy(scan_busy), .dbg_state_o(dbg_state)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_box(input int px, input int py, input int tx, input int ty, input int s);
        int lox, loy;
        lox = (tx - s < 0) ? 0 : tx - s;
        loy = (ty - s < 0) ? 0 : ty - s;
        return (px >= lox) && (px <= tx + s) && (py >= loy) && (py <= ty + s);
    endfunction

    // driver tasks
    task automatic clear_slots();
        bx = '0; by = '0; act = '0;
    endtask

    task automatic set_slot(input int i, input int x, input int y, input bit a);
        bx[i*10 +: 10] = x[9:0];
        by[i*10 +: 10] = y[9:0];
        act[i] = a;
    endtask

    task automatic set_tanks(input int ax, input int ay, input int bx2, input int by2, input int s);
        t1x = ax[9:0]; t1y = ay[9:0]; t2x = bx2[9:0]; t2y = by2[9:0]; tsz = s[9:0];
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_kill"}, bullet_kill, 0);
        check_eq({tag, "_hits"}, {tank1_hit, tank2_hit}, 0);
        check_eq({tag, "_freeze"}, freeze, 0);
        check_eq({tag, "_restart"}, round_restart, 0);
        check_eq({tag, "_scores"}, {score1, score2}, 0);
        check_eq({tag, "_over"}, game_over, 0);
        check_eq({tag, "_busy"}, scan_busy, 0);
        check_eq({tag, "_state"}, dbg_state, ST_WAIT);
    endtask

    task automatic do_reset();
        tick = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_s1 = 0; m_s2 = 0; m_mode = 0; m_h1 = 0; m_h2 = 0;
        exp_q.delete();
        @(negedge clk);
        check_idle_outputs("reset");
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic scan_frame(input bit perturb);
        logic [NB-1:0] ke;
        bit h1, h2;
        int px, py;
        ke = '0; h1 = 0; h2 = 0;
        for (int i = 0; i < NB; i++) begin
            px = int'(bx[i*10 +: 10]);
            py = int'(by[i*10 +: 10]);
            if (act[i] && in_box(px, py, t1x, t1y, tsz)) begin ke[i] = 1'b1; h1 = 1; end
            if (act[i] && in_box(px, py, t2x, t2y, tsz)) begin ke[i] = 1'b1; h2 = 1; end
        end
        exp_q.push_back(ke);
        if (h1 && !h2 && m_s2 < 15) m_s2++;
        if (h2 && !h1 && m_s1 < 15) m_s1++;
        m_h1 = h1; m_h2 = h2;
        if (!h1 && !h2)                     m_mode = 0;
        else if (m_s1 >= WIN || m_s2 >= WIN) m_mode = 2;
        else                                 m_mode = 1;

        @(negedge clk);
        pulse_tick();
        if (perturb) begin
            bx = ~bx; by = ~by; act = ~act;
            t1x = t1x + 10'd1; tsz = tsz + 10'd3;
        end
        for (int c = 0; c < NB + 1; c++) begin
            check_eq("scan_busy", scan_busy, 1);
            check_eq("kill_early", bullet_kill, 0);
            if (perturb && c == 1) tick = 1'b1;
            if (c == 2) tick = 1'b0;
            @(negedge clk);
        end
        check_eq("kill", bullet_kill, exp_q.pop_front());
        check_eq("tank1_hit", tank1_hit, m_h1);
        check_eq("tank2_hit", tank2_hit, m_h2);
        check_eq("score1", score1, m_s1);
        check_eq("score2", score2, m_s2);
        check_eq("freeze", freeze, (m_mode != 0));
        check_eq("game_over", game_over, (m_mode == 2));
        check_eq("busy_done", scan_busy, 0);
        @(negedge clk);
        check_eq("kill_pulse", bullet_kill, 0);
    endtask

    task automatic run_hold();
        for (int i = 0; i < HOLD; i++) begin
            check_eq("hold_freeze", freeze, 1);
            check_eq("hold_restart", round_restart, 0);
            check_eq("hold_hits", {tank1_hit, tank2_hit}, {m_h1, m_h2});
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pulse_tick();
        end
        check_eq("restart_pulse", round_restart, 1);
        check_eq("restart_freeze", freeze, 0);
        check_eq("restart_hits", {tank1_hit, tank2_hit}, 0);
        @(negedge clk);
        check_eq("restart_end", round_restart, 0);
        m_mode = 0;
    endtask

    task automatic run_over();
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            @(negedge clk);
        end
        repeat (NB + 2) @(negedge clk);
        check_eq("over_flag", game_over, 1);
        check_eq("over_freeze", freeze, 1);
        check_eq("over_busy", scan_busy, 0);
        check_eq("over_restart", round_restart, 0);
        check_eq("over_scores", {score1, score2}, {m_s1[3:0], m_s2[3:0]});
    endtask

    task automatic play_frame(input bit perturb);
        scan_frame(perturb);
        if (m_mode == 1) run_hold();
        else if (m_mode == 2) begin
            run_over();
            do_reset();
        end
    endtask

    task automatic random_frame();
        int tx, ty, s, x, y, sel;
        set_tanks(($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023),
                  $urandom_range(0, 1023),
                  $urandom_range(0, 1023),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 1023),
                  $urandom_range(0, 20));
        clear_slots();
        for (int i = 0; i < NB; i++) begin
            sel = $urandom_range(0, 1);
            tx = sel ? int'(t2x) : int'(t1x);
            ty = sel ? int'(t2y) : int'(t1y);
            s  = int'(tsz);
            x  = tx + $urandom_range(0, 2 * s + 4) - s - 2;
            y  = ty + $urandom_range(0, 2 * s + 4) - s - 2;
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            set_slot(i, x, y, ($urandom_range(0, 3) == 0));
        end
        play_frame(0);
    endtask

    initial begin
        tick = 1'b0;
        rst = 1'b0;
        set_tanks(0, 0, 0, 0, 0);
        clear_slots();
        do_reset();

        // corner hit on tank1, full hold
        set_tanks(100, 100, 900, 900, 8);
        set_slot(2, 108, 92, 1);
        play_frame(0);

        // saturated low bound on tank2; inactive far slot ignored
        clear_slots();
        set_tanks(500, 500, 5, 5, 8);
        set_slot(0, 0, 0, 1);
        set_slot(1, 1000, 1000, 0);
        play_frame(0);

        // mutual hit is a draw
        clear_slots();
        set_tanks(200, 200, 600, 600, 10);
        set_slot(4, 210, 190, 1);
        set_slot(5, 590, 610, 1);
        play_frame(0);

        // inputs and ticks after the snapshot must not matter
        clear_slots();
        set_tanks(300, 300, 800, 800, 5);
        set_slot(3, 305, 305, 1);
        play_frame(1);

        // drive tank2 hits until the game ends
        for (int r = 0; r < 8 && m_s1 < WIN; r++) begin
            clear_slots();
            set_tanks(100, 100, 700, 700, 4);
            set_slot(0, 700, 700, 1);
            play_frame(0);
        end

        // abort mid-scan with a pending hit
        clear_slots();
        set_tanks(100, 100, 900, 900, 8);
        set_slot(4, 100, 100, 1);
        @(negedge clk);
        pulse_tick();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check_eq("abort_kill", bullet_kill, 0);
            check_eq("abort_scores", {score1, score2}, 0);
            check_eq("abort_state", dbg_state, ST_WAIT);
            @(negedge clk);
        end
        m_s1 = 0; m_s2 = 0; m_mode = 0; m_h1 = 0; m_h2 = 0;

        // a quiet frame with nothing active
        clear_slots();
        play_frame(0);

        for (int f = 0; f < 25; f++) random_frame();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
